// File: rtl/beam_thresh_loader.sv
// Host-side loader for the beamformer threshold cascade. It keeps a per-beam table for two
// threshold sets, shifts the selected sets out highest beam first, then strobes the commit.
//
// state  | meaning
// IDLE   | waiting for start; host table writes accepted
// SHIFT  | one table read per cycle, beam NBEAMS-1 down to 0, then one drain cycle
// UPDATE | commit strobe on the latched set mask
// DONE   | done_o pulse; start ignored, host writes flagged
module beam_thresh_loader #(
  parameter int NBEAMS      = 48,
  parameter int THRESH_BITS = 18,
  parameter int AW          = $clog2(NBEAMS) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [AW-1:0]            host_addr_i,
  input  logic [THRESH_BITS-1:0]   host_wdata_i,
  input  logic                     host_we_i,
  input  logic                     start_i,
  input  logic [1:0]               set_mask_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     wr_err_o,
  output logic [2*THRESH_BITS-1:0] thresh_o,
  output logic [1:0]               thresh_wr_o,
  output logic [1:0]               thresh_update_o
);

  localparam int BW = AW - 1;
  localparam int IW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE, DONE} state_t;

  state_t                   state;
  logic [IW-1:0]            cnt;
  logic                     drain;
  logic [1:0]               mask_q;

  // Entries are stored inverted so a zero-initialised RAM reads back as all ones.
  logic [2*THRESH_BITS-1:0] tbl [NBEAMS];

  logic                     host_set;
  logic [BW-1:0]            host_beam;
  logic                     host_ok;
  logic [2*THRESH_BITS-1:0] lane_mask;

  assign host_set  = host_addr_i[AW-1];
  assign host_beam = host_addr_i[BW-1:0];
  assign host_ok   = host_we_i && (state == IDLE) && (AW'(host_beam) < AW'(NBEAMS));
  assign lane_mask = {{THRESH_BITS{mask_q[1]}}, {THRESH_BITS{mask_q[0]}}};

  always_ff @(posedge clk_i) begin
    if (host_ok) begin
      if (host_set) tbl[host_beam[IW-1:0]][2*THRESH_BITS-1:THRESH_BITS] <= ~host_wdata_i;
      else          tbl[host_beam[IW-1:0]][THRESH_BITS-1:0]             <= ~host_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      drain           <= 1'b0;
      mask_q          <= 2'b00;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      wr_err_o        <= 1'b0;
      thresh_o        <= '0;
      thresh_wr_o     <= 2'b00;
      thresh_update_o <= 2'b00;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && (set_mask_i != 2'b00)) begin
            state    <= SHIFT;
            mask_q   <= set_mask_i;
            cnt      <= IW'(NBEAMS - 1);
            drain    <= 1'b0;
            busy_o   <= 1'b1;
            wr_err_o <= 1'b0;
          end
        end
        SHIFT: begin
          if (!drain) begin
            thresh_o    <= ~tbl[cnt] & lane_mask;
            thresh_wr_o <= mask_q;
            if (cnt == '0) drain <= 1'b1;
            else           cnt   <= cnt - 1'b1;
          end else begin
            thresh_o        <= '0;
            thresh_wr_o     <= 2'b00;
            thresh_update_o <= mask_q;
            state           <= UPDATE;
          end
        end
        UPDATE: begin
          thresh_update_o <= 2'b00;
          busy_o          <= 1'b0;
          done_o          <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed after the case so a dropped write beats a same-edge clear.
      if (host_we_i && (state != IDLE)) wr_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Bench for beam_thresh_loader: directed loads plus randomized table contents and masks,
// checked cycle by cycle against a table model and the load timeline.
module tb_beam_thresh_loader;

  localparam int N  = 4;
  localparam int TB = 18;
  localparam int AW = 4;
  localparam int BW = AW - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [AW-1:0]     host_addr_i = '0;
  logic [TB-1:0]     host_wdata_i = '0;
  logic              host_we_i = 1'b0;
  logic              start_i = 1'b0;
  logic [1:0]        set_mask_i = 2'b00;
  logic              busy_o;
  logic              done_o;
  logic              wr_err_o;
  logic [2*TB-1:0]   thresh_o;
  logic [1:0]        thresh_wr_o;
  logic [1:0]        thresh_update_o;

  always #5 clk_i = ~clk_i;

  beam_thresh_loader #(.NBEAMS(N), .THRESH_BITS(TB), .AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_we_i(host_we_i), .start_i(start_i), .set_mask_i(set_mask_i), .busy_o(busy_o),
    .done_o(done_o), .wr_err_o(wr_err_o), .thresh_o(thresh_o), .thresh_wr_o(thresh_wr_o),
    .thresh_update_o(thresh_update_o)
  );

  int            vectors = 0;
  int            miscompares = 0;
  logic [TB-1:0] mdl [2][N];
  logic          err_exp = 1'b0;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input int k, input logic eb, input logic ed, input logic ee,
                         input logic [1:0] ew, input logic [1:0] eu, input logic [2*TB-1:0] et);
    chk("busy",   k, 64'(busy_o),          64'(eb));
    chk("done",   k, 64'(done_o),          64'(ed));
    chk("wr_err", k, 64'(wr_err_o),        64'(ee));
    chk("wr",     k, 64'(thresh_wr_o),     64'(ew));
    chk("update", k, 64'(thresh_update_o), 64'(eu));
    chk("thresh", k, 64'(thresh_o),        64'(et));
  endtask

  task automatic host_write(input logic s, input int beam, input logic [TB-1:0] d);
    @(negedge clk_i);
    host_addr_i  = {s, BW'(beam)};
    host_wdata_i = d;
    host_we_i    = 1'b1;
    @(posedge clk_i);
    #1 host_we_i = 1'b0;
    if (beam < N) mdl[s][beam] = d;
  endtask

  // Cycle k is the interval after edge k-1; start is sampled at edge 0.
  task automatic do_load(input logic [1:0] m, input bit pre, input int last_k,
                         input int xs_a, input int xs_b, input logic [1:0] xm,
                         input int wr_k, input logic [AW-1:0] wa, input logic [TB-1:0] wd,
                         input int rst_k);
    bit            act;
    bit            shifting;
    int            beam;
    int            wb;
    logic [1:0]    ewr;
    logic [1:0]    eup;
    logic [2*TB-1:0] eth;
    if (!pre) begin
      @(negedge clk_i);
      start_i    = 1'b1;
      set_mask_i = m;
    end
    act = (m != 2'b00);
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk_i);
      #1;
      start_i    = 1'b0;
      set_mask_i = 2'b00;
      host_we_i  = 1'b0;
      if (k == 1 && act) err_exp = 1'b0;
      shifting = act && (k >= 2) && (k <= N + 1);
      ewr = shifting ? m : 2'b00;
      eth = '0;
      if (shifting) begin
        beam = N + 1 - k;
        if (m[0]) eth[TB-1:0]    = mdl[0][beam];
        if (m[1]) eth[2*TB-1:TB] = mdl[1][beam];
      end
      eup = (act && k == N + 2) ? m : 2'b00;
      chk_all(k, act && (k <= N + 2), act && (k == N + 3), err_exp, ewr, eup, eth);
      if (k == rst_k) begin
        rst_i = 1'b1;
        #1;
        chk_all(k, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, '0);
        err_exp = 1'b0;
        act     = 1'b0;
        rst_i   = 1'b0;
      end
      if (k == xs_a || k == xs_b) begin
        start_i    = 1'b1;
        set_mask_i = xm;
      end
      if (k == wr_k) begin
        host_we_i    = 1'b1;
        host_addr_i  = wa;
        host_wdata_i = wd;
        if (act && k <= N + 3) err_exp = 1'b1;
        else begin
          wb = int'(wa[AW-2:0]);
          if (wb < N) mdl[wa[AW-1]][wb] = wd;
        end
      end
    end
    host_we_i = 1'b0;
    if (!(xs_a == last_k || xs_b == last_k)) begin
      start_i    = 1'b0;
      set_mask_i = 2'b00;
    end
  endtask

  initial begin
    logic [1:0] m;
    int xs;
    int wk;
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < N; b++) mdl[s][b] = '1;

    repeat (2) @(posedge clk_i);
    #1 chk_all(0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, '0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Power-up table contents
    do_load(2'b01, 1'b0, N + 5, 0, 0, 2'b00, 0, '0, '0, 0);

    host_write(1'b0, 0, 18'd100);
    host_write(1'b0, 1, 18'd200);
    host_write(1'b0, 2, 18'd300);
    host_write(1'b0, 3, 18'd400);
    host_write(1'b1, 0, 18'd5);
    host_write(1'b1, 1, 18'd6);
    host_write(1'b1, 2, 18'd7);
    host_write(1'b1, 3, 18'd8);

    do_load(2'b01, 1'b0, N + 5, 0, 0, 2'b00, 0, '0, '0, 0);
    do_load(2'b11, 1'b0, N + 5, 0, 0, 2'b00, 0, '0, '0, 0);

    // Stray starts in cycles 3 and 7, dropped write in cycle 3
    do_load(2'b01, 1'b0, N + 5, 3, 7, 2'b11, 3, {1'b0, 3'd2}, 18'd999, 0);
    @(posedge clk_i);
    #1 chk("err_sticky", 0, 64'(wr_err_o), 64'(1'b1));
    do_load(2'b01, 1'b0, N + 5, 0, 0, 2'b00, 0, '0, '0, 0);

    do_load(2'b11, 1'b0, N + 5, 0, 0, 2'b00, 0, '0, '0, 4);
    do_load(2'b11, 1'b0, N + 5, 0, 0, 2'b00, 0, '0, '0, 0);

    // Empty mask and out-of-range beam write
    do_load(2'b00, 1'b0, N + 5, 0, 0, 2'b00, 2, {1'b0, 3'd5}, 18'd12345, 0);
    do_load(2'b01, 1'b0, N + 5, 0, 0, 2'b00, 0, '0, '0, 0);

    // Start in the cycle after done_o is accepted
    do_load(2'b10, 1'b0, N + 4, N + 4, 0, 2'b01, 0, '0, '0, 0);
    do_load(2'b01, 1'b1, N + 5, 0, 0, 2'b00, 0, '0, '0, 0);

    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 4)); w++)
        host_write(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), TB'($urandom));
      m  = 2'($urandom_range(0, 3));
      xs = (m != 2'b00) ? int'($urandom_range(2, N + 3)) : 0;
      wk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N + 3)) : 0;
      do_load(m, 1'b0, N + 5, xs, 0, 2'($urandom), wk, AW'($urandom), TB'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/beam_thresh_loader.md
Name: beam_thresh_loader

Overview:
- Host-side writer for the beamformer threshold interface (threshold data, per-set write strobes, per-set update strobes).
- Holds a local table of per-beam thresholds for two threshold sets (set 0 = trigger, set 1 = servo), each THRESH_BITS wide.
- On a host start command, serially shifts the selected set(s) into the beam DSP cascade, then issues the commit (update) strobe.
- Sits between the register/control bus and the beamform trigger block.

Parameters:
- NBEAMS, 48, number of beams in the cascade, one threshold entry per beam per set.
- THRESH_BITS, 18, width of one threshold value.
- AW, $clog2(NBEAMS)+1, host address width; the MSB selects the set, the LSBs select the beam.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  reset, asynchronous, active-high.
- host_addr_i  in  AW  table address {set, beam}.
- host_wdata_i  in  THRESH_BITS  table write data.
- host_we_i  in  1  table write strobe.
- start_i  in  1  load request pulse.
- set_mask_i  in  2  sets to load on start; bit s = set s.
- busy_o  out  1  load sequence in progress.
- done_o  out  1  one-cycle pulse when a load completes.
- wr_err_o  out  1  sticky flag: a host write was dropped because a load was in progress.
- thresh_o  out  2*THRESH_BITS  lane s = bits [THRESH_BITS*s +: THRESH_BITS].
- thresh_wr_o  out  2  per-set cascade shift strobe.
- thresh_update_o  out  2  per-set commit strobe.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE.
  - Reset does not clear the table.
  - The table powers up with every entry = all ones (maximum threshold).
- Table: 2*NBEAMS entries, one write port, one synchronous read port.
  - A host write in IDLE updates the entry on the next edge.
  - Writes to a beam field >= NBEAMS are ignored.
- FSM states: IDLE, SHIFT, UPDATE, DONE.
- IDLE -> SHIFT: start_i=1 and set_mask_i != 0 at edge 0.
  - set_mask_i is latched at edge 0.
  - start_i with mask 0 is ignored.
  - start_i outside IDLE is ignored and is not queued.
- SHIFT: a beam counter runs NBEAMS-1 down to 0, one table read per cycle.
  - Read data is registered onto thresh_o. The paired thresh_wr_o[s] is asserted for the latched set bits only.
  - Write strobes are high in cycles 2..NBEAMS+1, one per beam, in descending beam order. After the last shift, beam b holds entry b.
  - Unselected lanes drive 0 with strobe 0.
  - With mask 2'b11, both lanes shift in the same cycles.
- UPDATE: thresh_update_o = latched mask for exactly one cycle (cycle NBEAMS+2). thresh_wr_o = 0 and thresh_o = 0.
- DONE: done_o = 1 for one cycle (cycle NBEAMS+3), then return to IDLE.
- busy_o is high in cycles 1..NBEAMS+2 and low in the done_o cycle.
  - A start_i in the done_o cycle is ignored.
  - A start_i in the cycle after done_o is accepted.
- Host write while busy_o=1 or in the DONE cycle: the write is dropped and wr_err_o sets.
  - wr_err_o clears on the next accepted start. If set and clear land on the same edge, set wins.
- Reset mid-sequence: strobes drop immediately (asynchronous) and no update strobe is issued. Beams therefore keep their previously committed thresholds. The partially shifted cascade contents are overwritten by the next full load.
- thresh_wr_o and thresh_update_o are never high in the same cycle.
- All outputs are registered.

Test Plan:
- NBEAMS=4: write set0 entries {100,200,300,400}, start with mask 01.
  - thresh_wr_o=01 in cycles 2..5, lane0 carrying 400,300,200,100.
  - thresh_update_o=01 in cycle 6; done_o in cycle 7; busy_o high in cycles 1..6.
- Set1 entries {5,6,7,8}, set0 as above, mask 11.
  - Both lanes shift together, lane1 carrying 8,7,6,5.
  - thresh_update_o=11 in a single cycle.
- Extra start_i pulses in cycles 3 and 7 of an active load.
  - Both are ignored; exactly one update strobe and one done_o for the load.
- host_we_i in cycle 3 to set0 beam 2 with value 999.
  - wr_err_o=1, and the entry keeps its old value on the next load (300 seen).
  - The next accepted start clears wr_err_o.
- rst_i pulsed in cycle 4 of a load.
  - Strobes go 0 asynchronously; no update strobe and no done_o.
  - A following full load shifts the unchanged table correctly.
- start_i with mask 00, and a write to beam field 5 with NBEAMS=4.
  - No strobes, busy_o stays 0, table unchanged.
- No writes after power-up, then a load with mask 01.
  - All shifted values are 18'h3FFFF.
